south_result_collector: RTL and testbench

- Receiving end of the systolic array's south edge: samples each column's outp_south stream from the bottom-row PEs.
- Removes the one-cycle-per-column skew so each result row becomes one aligned word.
- Buffers aligned rows in a small FIFO and hands them downstream over a valid/ready handshake.
- The array cannot stall, so the collector never back-pressures it; a full FIFO causes a row to be dropped and flagged.

---
 rtl/south_result_collector.sv | 184 ++++++++++++++++++
 tb/tb_south_result_collector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/south_result_collector.sv
// South-edge result collector for the systolic array.
// Each bottom-row column arrives one cycle later than its left neighbour;
// per-column delay lines re-align a result row into one word, which is
// pushed into a small show-ahead FIFO and handed downstream.
// The array cannot be stalled, so a full FIFO drops the row and raises a
// sticky overflow flag instead of back-pressuring.
//
// Downstream handshake: out_valid means the FIFO head is on out_data.
// A transfer happens on a rising edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0, out_data holds steady.
// out_valid never drops without a transfer.
module south_result_collector #(
    parameter int COLS   = 4,
    parameter int DATA_W = 32,
    parameter int LAT    = 3,
    parameter int DEPTH  = 4,
    parameter int ROW_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W-1:0]         row_count,
    input  logic [COLS*DATA_W-1:0]   south_in,
    output logic [COLS*DATA_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);

    localparam int W         = COLS * DATA_W;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW    = PTR_W + 1;
    localparam int WAIT_INIT = LAT + COLS - 2;
    localparam int CNT_W     = $clog2(WAIT_INIT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [ROW_W-1:0]    r_rows_left;
    logic                r_done;
    logic                r_overflow;

    logic [DATA_W-1:0]   w_col [COLS];
    logic [W-1:0]        w_row;

    logic [W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_FW-1:0]   r_count;
    logic [W-1:0]        r_hold;
    logic [W-1:0]        w_head;

    logic                w_start_run;
    logic                w_start_zero;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;

    // Column c needs COLS-1-c stages so it lines up with the last column,
    // which is taken straight from the input on the push edge.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        if (c == COLS - 1) begin : g_direct
            assign w_col[c] = south_in[c*DATA_W +: DATA_W];
        end else begin : g_dly
            localparam int STG = COLS - 1 - c;
            logic [DATA_W-1:0] r_dly [STG];

            // Shift the column through its skew-removal delay line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < STG; s++) r_dly[s] <= '0;
                end else begin
                    r_dly[0] <= south_in[c*DATA_W +: DATA_W];
                    for (int s = 1; s < STG; s++) r_dly[s] <= r_dly[s-1];
                end
            end

            assign w_col[c] = r_dly[STG-1];
        end
    end

    // Pack the aligned columns back into the south_in layout.
    always_comb begin
        w_row = '0;
        for (int c = 0; c < COLS; c++) w_row[c*DATA_W +: DATA_W] = w_col[c];
    end

    assign w_start_run  = (r_state == S_IDLE) && start && (row_count != '0);
    assign w_start_zero = (r_state == S_IDLE) && start && (row_count == '0);

    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == CNT_FW'(DEPTH));
    assign w_push    = (r_state == S_CAPTURE);
    assign w_pop     = out_valid && out_ready;
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: WAIT is skipped when the first row is due one edge after start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) w_state_nxt = (WAIT_INIT == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == CNT_W'(1)) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_rows_left == ROW_W'(1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Run counters, done pulse and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_rows_left <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= w_start_zero ||
                      ((r_state == S_CAPTURE) && (r_rows_left == ROW_W'(1)));
            if (w_start_run) begin
                r_wait_cnt  <= CNT_W'(WAIT_INIT);
                r_rows_left <= row_count;
                r_overflow  <= 1'b0;
            end else begin
                if (r_state == S_WAIT)    r_wait_cnt  <= r_wait_cnt - CNT_W'(1);
                if (r_state == S_CAPTURE) r_rows_left <= r_rows_left - ROW_W'(1);
                if (w_drop)               r_overflow  <= 1'b1;
            end
        end
    end

    // FIFO storage, pointers and occupancy; a full FIFO may push when it pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_row;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (out_valid) r_hold <= w_head;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_FW'(1);
                2'b01:   r_count <= r_count - CNT_FW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data  = out_valid ? w_head : r_hold;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_south_result_collector.sv
// Directed bench for south_result_collector (COLS=4, LAT=3, DEPTH=4).
// Column c of row r carries base + 0x100*r + c at edge T0+LAT+c+r.
module tb_south_result_collector;

    localparam int COLS   = 4;
    localparam int DATA_W = 32;
    localparam int LAT    = 3;
    localparam int DEPTH  = 4;
    localparam int ROW_W  = 8;
    localparam int W      = COLS * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROW_W-1:0] row_count;
    logic [W-1:0]     south_in;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [1:0]       dbg_state;

    int cyc    = 0;
    int t0     = 0;
    int d_rows = 0;
    int d_base = 0;
    int n_vec  = 0;
    int n_miss = 0;

    south_result_collector #(
        .COLS(COLS), .DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row_count(row_count),
        .south_in(south_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // Clock and edge counter: cyc equals the number of the last rising edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Array model: present the skewed south-edge stream for the next edge.
    initial begin
        south_in = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < COLS; c++) begin
                int r;
                r = cyc + 1 - t0 - LAT - c;
                if (r >= 0 && r < d_rows)
                    south_in[c*DATA_W +: DATA_W] = d_base + 32'h100 * r + c;
                else
                    south_in[c*DATA_W +: DATA_W] = '0;
            end
        end
    end

    function automatic logic [W-1:0] row_word(input int base, input int r);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < COLS; c++) w[c*DATA_W +: DATA_W] = base + 32'h100 * r + c;
        return w;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the falling edge following edge T0+n.
    task automatic at_edge(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    // Pulse start for edge T0; returns at the falling edge after T0.
    task automatic launch(input int rows, input int base);
        start     = 1'b1;
        row_count = ROW_W'(rows);
        t0        = cyc + 1;
        d_rows    = rows;
        d_base    = base;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);

        // Basic alignment, two rows, ready high.
        out_ready = 1'b1;
        launch(2, 0);
        check("t1_busy0", busy, 1);
        check("t1_wait", dbg_state, 1);
        at_edge(5);
        check("t1_nopush", out_valid, 0);
        check("t1_capture", dbg_state, 2);
        at_edge(6);
        check("t1_v0", out_valid, 1);
        check("t1_row0", out_data, row_word(0, 0));
        check("t1_nodone", done, 0);
        check("t1_busy6", busy, 1);
        at_edge(7);
        check("t1_v1", out_valid, 1);
        check("t1_row1", out_data, row_word(0, 1));
        check("t1_done", done, 1);
        check("t1_idle", busy, 0);
        check("t1_ovf", overflow, 0);
        at_edge(8);
        check("t1_empty", out_valid, 0);
        check("t1_done_end", done, 0);

        // Back-pressure: six rows into a four-row FIFO.
        out_ready = 1'b0;
        launch(6, 0);
        at_edge(9);
        check("t2_v", out_valid, 1);
        check("t2_head", out_data, row_word(0, 0));
        check("t2_ovf_pre", overflow, 0);
        at_edge(10);
        check("t2_ovf", overflow, 1);
        check("t2_hold", out_data, row_word(0, 0));
        at_edge(11);
        check("t2_done", done, 1);
        check("t2_ovf_sticky", overflow, 1);
        at_edge(13);
        check("t2_drain0", out_data, row_word(0, 0));
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            at_edge(13 + k);
            check("t2_drain_v", out_valid, 1);
            check("t2_drain", out_data, row_word(0, k));
        end
        at_edge(17);
        check("t2_empty", out_valid, 0);
        check("t2_ovf_kept", overflow, 1);
        out_ready = 1'b0;

        // Full FIFO with simultaneous pop and push.
        launch(5, 0);
        check("t3_ovf_clr", overflow, 0);
        at_edge(9);
        check("t3_head", out_data, row_word(0, 0));
        out_ready = 1'b1;
        at_edge(10);
        check("t3_pop", out_data, row_word(0, 1));
        check("t3_ovf", overflow, 0);
        check("t3_done", done, 1);
        out_ready = 1'b0;
        at_edge(12);
        check("t3_hold", out_data, row_word(0, 1));
        out_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            at_edge(11 + k);
            check("t3_drain_v", out_valid, 1);
            check("t3_drain", out_data, row_word(0, k));
        end
        at_edge(16);
        check("t3_empty", out_valid, 0);

        // Second start during WAIT is ignored.
        launch(2, 32'h7000);
        at_edge(2);
        start = 1'b1; row_count = 8'd5;
        @(negedge clk);
        start = 1'b0;
        at_edge(6);
        check("t4_row0", out_data, row_word(32'h7000, 0));
        at_edge(7);
        check("t4_row1", out_data, row_word(32'h7000, 1));
        check("t4_done", done, 1);
        at_edge(8);
        check("t4_busy", busy, 0);
        at_edge(12);
        check("t4_nopush", out_valid, 0);
        check("t4_idle", busy, 0);

        // Zero-row run.
        launch(0, 0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        check("t5_valid", out_valid, 0);
        at_edge(1);
        check("t5_done_end", done, 0);
        check("t5_busy_end", busy, 0);
        check("t5_valid_end", out_valid, 0);

        // Reset in the middle of a three-row run.
        launch(3, 32'h2000);
        at_edge(4);
        rst = 1'b1;
        at_edge(5);
        rst = 1'b0;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_state", dbg_state, 0);
        at_edge(8);
        check("t6_nopush", out_valid, 0);
        check("t6_nodone8", done, 0);
        at_edge(9);
        check("t6_nodone9", done, 0);

        // Fresh run after reset.
        launch(3, 32'h5000);
        at_edge(6);
        check("t7_row0", out_data, row_word(32'h5000, 0));
        at_edge(7);
        check("t7_row1", out_data, row_word(32'h5000, 1));
        at_edge(8);
        check("t7_row2", out_data, row_word(32'h5000, 2));
        check("t7_done", done, 1);
        at_edge(9);
        check("t7_empty", out_valid, 0);
        check("t7_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
